// File: rtl/fg_burst_scheduler.sv
// Burst pacing scheduler: splits each accepted flow descriptor into burst descriptors.
// A debt accumulator spaces paced bursts so the average rate follows rate_num/rate_denom.
module fg_burst_scheduler #(
    parameter int DEST_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  input_fd_valid,
    output logic                  input_fd_ready,
    input  logic [DEST_WIDTH-1:0] input_fd_dest,
    input  logic [15:0]           input_fd_rate_num,
    input  logic [15:0]           input_fd_rate_denom,
    input  logic [31:0]           input_fd_len,
    input  logic [31:0]           input_fd_burst_len,
    output logic                  output_bd_valid,
    input  logic                  output_bd_ready,
    output logic [DEST_WIDTH-1:0] output_bd_dest,
    output logic [31:0]           output_bd_len,
    output logic                  busy,
    output logic                  flow_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, OUT} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [47:0]           r_debt;
    logic [15:0]           r_num;
    logic [15:0]           r_denom;
    logic [DEST_WIDTH-1:0] r_dest;
    logic [31:0]           r_remaining;
    logic [31:0]           r_blen;
    logic                  r_bd_valid;
    logic [DEST_WIDTH-1:0] r_bd_dest;
    logic [31:0]           r_bd_len;
    logic                  r_flow_done;

    logic                  w_accept;
    logic                  w_load;
    logic                  w_hs;
    logic                  w_reload;
    logic                  w_finish;
    logic                  w_unpaced;
    logic                  w_last;
    logic [31:0]           w_rem_after;
    logic [31:0]           w_issue_len;
    logic [31:0]           w_reload_len;
    logic [47:0]           w_cost;
    logic [47:0]           w_debt_dec;
    logic [48:0]           w_debt_sum;
    logic [47:0]           w_debt_next;

    assign w_unpaced    = (r_num == '0) || (r_num >= r_denom);
    assign w_last       = (r_remaining == r_bd_len);
    assign w_rem_after  = r_remaining - r_bd_len;
    assign w_issue_len  = (r_remaining < r_blen) ? r_remaining : r_blen;
    assign w_reload_len = (w_rem_after < r_blen) ? w_rem_after : r_blen;

    // Debt drains by num every cycle (floored at zero), then gains the cost of a paced handshake.
    assign w_cost      = (w_hs && !w_unpaced) ? (48'(r_bd_len) * 48'(r_denom)) : '0;
    assign w_debt_dec  = (r_debt > 48'(r_num)) ? (r_debt - 48'(r_num)) : '0;
    assign w_debt_sum  = {1'b0, w_debt_dec} + {1'b0, w_cost};
    assign w_debt_next = w_debt_sum[48] ? '1 : w_debt_sum[47:0];

    always_comb begin
        w_state_next   = r_state;
        input_fd_ready = 1'b0;
        w_accept       = 1'b0;
        w_load         = 1'b0;
        w_hs           = 1'b0;
        w_reload       = 1'b0;
        w_finish       = 1'b0;
        case (r_state)
            IDLE: begin
                input_fd_ready = 1'b1;
                if (input_fd_valid) begin
                    w_accept = 1'b1;
                    if (input_fd_len != '0) begin
                        w_state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (enable && (r_debt == '0)) begin
                    w_load       = 1'b1;
                    w_state_next = OUT;
                end
            end
            OUT: begin
                if (output_bd_ready) begin
                    w_hs = 1'b1;
                    if (w_last) begin
                        w_finish     = 1'b1;
                        w_state_next = IDLE;
                    end else if (w_unpaced && enable) begin
                        w_reload = 1'b1;
                    end else begin
                        w_state_next = ISSUE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_debt      <= '0;
            r_num       <= '0;
            r_denom     <= '0;
            r_dest      <= '0;
            r_remaining <= '0;
            r_blen      <= '0;
            r_bd_valid  <= 1'b0;
            r_bd_dest   <= '0;
            r_bd_len    <= '0;
            r_flow_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_debt      <= w_debt_next;
            r_flow_done <= 1'b0;
            if (w_accept) begin
                if (input_fd_len == '0) begin
                    r_flow_done <= 1'b1;
                end else begin
                    r_dest      <= input_fd_dest;
                    r_num       <= input_fd_rate_num;
                    r_denom     <= input_fd_rate_denom;
                    r_remaining <= input_fd_len;
                    r_blen      <= (input_fd_burst_len == '0) ? input_fd_len : input_fd_burst_len;
                end
            end
            if (w_load) begin
                r_bd_valid <= 1'b1;
                r_bd_dest  <= r_dest;
                r_bd_len   <= w_issue_len;
            end
            if (w_hs) begin
                r_remaining <= w_rem_after;
                if (w_reload) begin
                    r_bd_len <= w_reload_len;
                end else begin
                    r_bd_valid <= 1'b0;
                end
                if (w_finish) begin
                    r_flow_done <= 1'b1;
                end
            end
        end
    end

    assign output_bd_valid = r_bd_valid;
    assign output_bd_dest  = r_bd_dest;
    assign output_bd_len   = r_bd_len;
    assign busy            = (r_state != IDLE);
    assign flow_done       = r_flow_done;

endmodule

// File: tb/tb_fg_burst_scheduler.sv
// Bench for fg_burst_scheduler: a transaction-level model predicts every burst and flow_done,
// directed sections pin latency, pacing spacing, backpressure, enable and reset behaviour.
module tb_fg_burst_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        input_fd_valid = 1'b0;
    logic        input_fd_ready;
    logic [7:0]  input_fd_dest = '0;
    logic [15:0] input_fd_rate_num = '0;
    logic [15:0] input_fd_rate_denom = '0;
    logic [31:0] input_fd_len = '0;
    logic [31:0] input_fd_burst_len = '0;
    logic        output_bd_valid;
    logic        output_bd_ready = 1'b1;
    logic [7:0]  output_bd_dest;
    logic [31:0] output_bd_len;
    logic        busy;
    logic        flow_done;

    fg_burst_scheduler #(.DEST_WIDTH(8)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable              (enable),
        .input_fd_valid      (input_fd_valid),
        .input_fd_ready      (input_fd_ready),
        .input_fd_dest       (input_fd_dest),
        .input_fd_rate_num   (input_fd_rate_num),
        .input_fd_rate_denom (input_fd_rate_denom),
        .input_fd_len        (input_fd_len),
        .input_fd_burst_len  (input_fd_burst_len),
        .output_bd_valid     (output_bd_valid),
        .output_bd_ready     (output_bd_ready),
        .output_bd_dest      (output_bd_dest),
        .output_bd_len       (output_bd_len),
        .busy                (busy),
        .flow_done           (flow_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: timeout at cycle %0d", name, cyc);
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic [7:0]  dest;
        logic [31:0] len;
        bit          last;
    } burst_t;

    burst_t      exp_q[$];
    int          hs_cyc[$];
    logic [31:0] hs_len[$];
    int          acc_cyc  = 0;
    bit          exp_busy = 1'b0;
    bit          exp_done = 1'b0;
    bit          prev_rst = 1'b1;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_dest;
    logic [31:0] prev_len;
    burst_t      m_b;
    logic [31:0] m_rem;
    logic [31:0] m_bl;

    always @(negedge clk) begin
        if (prev_rst) begin
            chk("rst_valid", output_bd_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", flow_done, 0);
            chk("rst_ready", input_fd_ready, 1);
            chk("rst_dest", output_bd_dest, 0);
            chk("rst_len", output_bd_len, 0);
        end else begin
            chk("busy", busy, exp_busy);
            chk("fd_ready", input_fd_ready, !exp_busy);
            chk("flow_done", flow_done, exp_done);
            if (!exp_busy) chk("valid_idle", output_bd_valid, 0);
            if (prev_stall) begin
                chk("stall_valid", output_bd_valid, 1);
                chk("stall_dest", output_bd_dest, prev_dest);
                chk("stall_len", output_bd_len, prev_len);
            end
        end
        exp_done = 1'b0;
        if (rst) begin
            exp_q.delete();
            exp_busy   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (output_bd_valid && output_bd_ready) begin
                hs_cyc.push_back(cyc);
                hs_len.push_back(output_bd_len);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_burst");
                end else begin
                    m_b = exp_q.pop_front();
                    chk("bd_dest", output_bd_dest, m_b.dest);
                    chk("bd_len", output_bd_len, m_b.len);
                    if (m_b.last) begin
                        exp_done = 1'b1;
                        exp_busy = 1'b0;
                    end
                end
            end
            if (input_fd_valid && input_fd_ready) begin
                acc_cyc = cyc;
                if (input_fd_len == 0) begin
                    exp_done = 1'b1;
                end else begin
                    exp_busy = 1'b1;
                    m_rem = input_fd_len;
                    m_bl  = (input_fd_burst_len == 0) ? input_fd_len : input_fd_burst_len;
                    while (m_rem > 0) begin
                        m_b.dest = input_fd_dest;
                        m_b.len  = (m_rem < m_bl) ? m_rem : m_bl;
                        m_rem    = m_rem - m_b.len;
                        m_b.last = (m_rem == 0);
                        exp_q.push_back(m_b);
                    end
                end
            end
            prev_stall = output_bd_valid && !output_bd_ready;
        end
        prev_rst  = rst;
        prev_dest = output_bd_dest;
        prev_len  = output_bd_len;
    end

    // ---------------- directed stimulus ----------------
    task automatic send_fd(input logic [7:0] d, input logic [31:0] len, input logic [31:0] bl,
                           input logic [15:0] num, input logic [15:0] den);
        int n;
        @(posedge clk); #1;
        input_fd_dest       = d;
        input_fd_len        = len;
        input_fd_burst_len  = bl;
        input_fd_rate_num   = num;
        input_fd_rate_denom = den;
        input_fd_valid      = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!input_fd_ready && n < 1000);
        if (!input_fd_ready) fail_now("send_fd");
        @(posedge clk); #1;
        input_fd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int busy_low);
        int n;
        n = 0;
        busy_low = 0;
        @(negedge clk);
        while (!flow_done && n < budget) begin
            if (!busy) busy_low++;
            @(negedge clk);
            n++;
        end
        if (!flow_done) fail_now("wait_done");
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!output_bd_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!output_bd_valid) fail_now("wait_valid");
    endtask

    task automatic clear_log();
        hs_cyc.delete();
        hs_len.delete();
    endtask

    initial begin
        int bl_cnt;
        int t_set;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_len", output_bd_len, 0);
        chk("post_rst_ready", input_fd_ready, 1);

        // Unpaced 3000/1024: three back-to-back bursts starting two cycles after accept
        clear_log();
        send_fd(8'h11, 3000, 1024, 1, 1);
        wait_done(200, bl_cnt);
        chk("up_count", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            chk("up_first", hs_cyc[0], acc_cyc + 2);
            chk("up_b2b1", hs_cyc[1], hs_cyc[0] + 1);
            chk("up_b2b2", hs_cyc[2], hs_cyc[1] + 1);
            chk("up_len0", hs_len[0], 1024);
            chk("up_len2", hs_len[2], 952);
        end

        // Backpressure, num=0 counts as unpaced
        clear_log();
        output_bd_ready = 1'b0;
        send_fd(8'h22, 2048, 1024, 0, 7);
        wait_valid(100);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", output_bd_valid, 1);
            chk("bp_dest", output_bd_dest, 8'h22);
            chk("bp_len", output_bd_len, 1024);
            if (i < 9) @(negedge clk);
        end
        chk("bp_no_hs", hs_cyc.size(), 0);
        @(posedge clk); #1;
        output_bd_ready = 1'b1;
        t_set = cyc;
        wait_done(200, bl_cnt);
        chk("bp_count", hs_cyc.size(), 2);
        if (hs_cyc.size() == 2) begin
            chk("bp_hs0", hs_cyc[0], t_set);
            chk("bp_b2b", hs_cyc[1], hs_cyc[0] + 1);
        end

        // enable gating in ISSUE, and enable ignored while valid
        clear_log();
        output_bd_ready = 1'b0;
        enable = 1'b0;
        send_fd(8'h33, 1500, 1000, 2, 2);
        repeat (50) begin
            @(negedge clk);
            chk("en_off_valid", output_bd_valid, 0);
        end
        @(posedge clk); #1;
        enable = 1'b1;
        @(negedge clk);
        chk("en_lat0", output_bd_valid, 0);
        @(negedge clk);
        chk("en_lat1", output_bd_valid, 1);
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("en_hold_valid", output_bd_valid, 1);
            chk("en_hold_len", output_bd_len, 1000);
        end
        @(posedge clk); #1;
        output_bd_ready = 1'b1;
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("en_gap_valid", output_bd_valid, 0);
        end
        @(posedge clk); #1;
        enable = 1'b1;
        wait_done(200, bl_cnt);
        chk("en_count", hs_len.size(), 2);
        if (hs_len.size() == 2) chk("en_len1", hs_len[1], 500);

        // len=0: dropped, flow_done pulses, ready stays high
        clear_log();
        send_fd(8'h44, 0, 100, 1, 1);
        @(negedge clk);
        chk("z_done", flow_done, 1);
        chk("z_ready", input_fd_ready, 1);
        chk("z_valid", output_bd_valid, 0);
        repeat (3) @(negedge clk);
        chk("z_no_hs", hs_cyc.size(), 0);

        // burst_len=0: single burst of len
        clear_log();
        send_fd(8'h45, 500, 0, 1, 1);
        wait_done(100, bl_cnt);
        chk("bl0_count", hs_len.size(), 1);
        if (hs_len.size() == 1) begin
            chk("bl0_len", hs_len[0], 500);
            chk("bl0_first", hs_cyc[0], acc_cyc + 2);
        end

        // Paced 1/4: 1024*4/1 + 2 = 4098 cycles between handshakes
        clear_log();
        send_fd(8'h55, 4096, 1024, 1, 4);
        wait_done(20000, bl_cnt);
        chk("pc_busy_low", bl_cnt, 0);
        chk("pc_count", hs_cyc.size(), 4);
        if (hs_cyc.size() == 4) begin
            chk("pc_first", hs_cyc[0], acc_cyc + 2);
            for (int i = 1; i < 4; i++) chk("pc_gap", hs_cyc[i] - hs_cyc[i-1], 4098);
        end

        // Reset mid paced flow with debt outstanding
        clear_log();
        send_fd(8'h66, 4096, 1024, 1, 4);
        begin
            int n;
            n = 0;
            while (hs_cyc.size() == 0 && n < 6000) begin
                @(negedge clk);
                n++;
            end
            if (hs_cyc.size() == 0) fail_now("rst_flow_hs");
        end
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mr_valid", output_bd_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_ready", input_fd_ready, 1);
        clear_log();
        send_fd(8'h77, 100, 0, 1, 1);
        wait_done(100, bl_cnt);
        chk("mr_count", hs_cyc.size(), 1);
        if (hs_cyc.size() == 1) begin
            chk("mr_first", hs_cyc[0], acc_cyc + 2);
            chk("mr_len", hs_len[0], 100);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fg_burst_scheduler.md
Name: fg_burst_scheduler

Overview:
Pacing scheduler that drains flow descriptors from the flow descriptor FIFO and splits each flow into burst descriptors for the frame generator datapath. Each flow carries a destination, a total byte length, a burst length and a rate fraction rate_num/rate_denom of line rate. A debt accumulator spaces burst issue so that each flow's average output rate matches its rate fraction. The block sits between the fg_fd_fifo output and the burst/frame generator input.

Parameters:
DEST_WIDTH, 8, width of the destination field on both interfaces

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
enable  input  1  when low, no new burst becomes valid; a burst already valid is held
input_fd_valid  input  1  flow descriptor valid
input_fd_ready  output  1  flow descriptor ready
input_fd_dest  input  DEST_WIDTH  flow destination
input_fd_rate_num  input  16  rate numerator
input_fd_rate_denom  input  16  rate denominator
input_fd_len  input  32  flow length in bytes
input_fd_burst_len  input  32  maximum burst length in bytes; 0 means a single burst of len
output_bd_valid  output  1  burst descriptor valid
output_bd_ready  input  1  burst descriptor ready
output_bd_dest  output  DEST_WIDTH  burst destination
output_bd_len  output  32  burst length in bytes
busy  output  1  high whenever state is not IDLE
flow_done  output  1  one-cycle pulse on the handshake of a flow's last burst

Behaviour:
- Reset: state IDLE; debt=0; latched fields=0; output_bd_valid=0; output_bd_dest=0; output_bd_len=0; busy=0; flow_done=0.
- Unpaced flow: rate_num==0 or rate_num>=rate_denom. It runs at line rate and adds no debt.
- Paced flow: each burst of L bytes adds L*rate_denom to debt. Multiplier is 32x16 into a 48-bit result; the add saturates at 2^48-1.
- Every cycle: debt_next = max(debt - num_latched, 0) + (issue cost on handshake, else 0). num_latched is the last accepted rate_num and persists in IDLE. Debt carries over between flows.
- IDLE: input_fd_ready=1.
  - Accept with input_fd_len==0: descriptor dropped, no burst, flow_done pulses the next cycle, stay in IDLE.
  - Accept otherwise: latch dest, num, denom, remaining=len, blen (burst_len, or len if burst_len==0) -> ISSUE.
- ISSUE: input_fd_ready=0. When enable==1 and registered debt==0:
  - load output_bd_dest=dest and output_bd_len=min(remaining, blen)
  - assert output_bd_valid -> OUT
- OUT: output_bd_valid=1; dest and len are held stable until output_bd_ready. enable has no effect here. On handshake:
  - remaining -= output_bd_len; apply the debt cost.
  - If this was the last burst (remaining==output_bd_len): flow_done=1 for one cycle; valid=0 -> IDLE.
  - Else if unpaced and enable==1: reload the next burst; valid stays 1; stay in OUT (back-to-back bursts).
  - Else: valid=0 -> ISSUE.
- Latency: descriptor accepted at cycle T -> output_bd_valid high at T+2 if debt==0.
- Paced spacing: handshake at cycle t -> next valid at t + L*denom/num + 2, when num divides L*denom.
- Remainders lost when debt floors at 0 are accepted pacing error, bounded at under one cycle per burst.
- The last burst of a flow may be shorter than blen. The sum of all burst lens always equals the flow len.
- Reset mid-flow: everything returns to reset values next cycle; the in-flight flow is discarded.

Test Plan:
- Unpaced: len=3000, burst_len=1024, num=denom=1, ready=1, enable=1 -> bursts 1024, 1024, 952 on 3 consecutive cycles starting T+2; flow_done on the 952 handshake.
- Paced: len=4096, burst_len=1024, num=1, denom=4, ready=1 -> 4 bursts of 1024, handshakes exactly 4098 cycles apart; busy high throughout.
- Backpressure: hold ready=0 for 10 cycles while valid -> valid, dest and len stable for all 10 cycles; one handshake when ready rises.
- enable=0 in ISSUE for 50 cycles -> no valid; valid appears 1 cycle after enable=1. enable dropping while valid -> valid held.
- Edge fields: len=0 -> no burst, flow_done pulse, ready stays high. burst_len=0, len=500 -> single burst of 500. num=0 -> unpaced.
- Reset during a paced flow with debt>0 -> next cycle: valid=0, busy=0, input_fd_ready=1; a new flow bursts at T+2.
